mem_port_arbiter: RTL

//  Shares the single-port unified instruction/data memory between the IF stage (fetch port i_*)
//  and the MEM stage (data port d_*) of the mips32 pipeline. Data port has priority, with a

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// Data wins by default; fetch is guaranteed a grant after MAX_D data grants in a row.
module mem_port_arbiter #(
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int MAX_D   = 3,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flush,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ready,
  input  logic [DW-1:0] m_rdata,
  output logic          err
);

  localparam int SW = $clog2(MAX_D + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] MAX_D_C   = SW'(MAX_D);
  localparam logic [WW-1:0] TIMEOUT_C = WW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, I_DROP} state_t;

  state_t        state, state_next;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wait_cnt;
  logic          grant_d, grant_i, done_d, done_i;
  logic          d_ok, i_ok;

  // A requester still seeing its own ack is holding a request that was just served.
  assign d_ok = d_req && !d_ack;
  assign i_ok = i_req && !i_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    done_d     = 1'b0;
    done_i     = 1'b0;
    case (state)
      IDLE: begin
        if (d_ok && (!i_req || i_flush || starve_cnt < MAX_D_C)) begin
          grant_d    = 1'b1;
          state_next = D_BUSY;
        end else if (i_ok && !i_flush) begin
          grant_i    = 1'b1;
          state_next = I_BUSY;
        end
      end
      I_BUSY: begin
        // A flushed fetch still has to finish on the memory side, just silently.
        if (i_flush) begin
          state_next = m_ready ? IDLE : I_DROP;
        end else if (m_ready) begin
          done_i     = 1'b1;
          state_next = IDLE;
        end
      end
      D_BUSY: begin
        if (m_ready) begin
          done_d     = 1'b1;
          state_next = IDLE;
        end
      end
      I_DROP: begin
        if (m_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      starve_cnt <= '0;
    end else begin
      i_ack <= done_i;
      d_ack <= done_d;
      if (grant_d) begin
        m_req   <= 1'b1;
        m_we    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else if (grant_i) begin
        m_req   <= 1'b1;
        m_we    <= 1'b0;
        m_addr  <= i_addr;
        m_wdata <= '0;
      end else if (state != IDLE && m_ready) begin
        m_req <= 1'b0;
      end
      if (done_i)            i_rdata <= m_rdata;
      if (done_d && !m_we)   d_rdata <= m_rdata;
      // Saturating count of data grants that overtook a live fetch request.
      if (grant_d) begin
        if (i_req && !i_flush) begin
          if (starve_cnt != MAX_D_C) starve_cnt <= starve_cnt + 1'b1;
        end else if (!i_req) begin
          starve_cnt <= '0;
        end
      end else if (grant_i) begin
        starve_cnt <= '0;
      end
    end
  end

  // Timeout only flags the slow memory; the access itself keeps waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else if (!m_req || m_ready) begin
      wait_cnt <= '0;
    end else if (wait_cnt != TIMEOUT_C) begin
      wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == TIMEOUT_C - 1'b1) err <= 1'b1;
    end
  end

endmodule
